// File: rtl/sb_pkg.sv
// Shared SB bus encodings and arbiter state type.
package sb_pkg;

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;

    localparam logic [1:0] RespOkay  = 2'd1;
    localparam logic [1:0] RespError = 2'd2;
    localparam logic [1:0] RespSplit = 2'd3;

    localparam logic MasterM1 = 1'b1;
    localparam logic MasterM2 = 1'b0;

    // Bit 0 is the M2 grant, so each grant output comes straight from one flop.
    typedef enum logic [1:0] {
        ArbM1   = 2'b00,
        ArbM2   = 2'b01,
        ArbPark = 2'b10
    } arb_state_e;

endpackage

// File: rtl/sb_arb_split_tracker.sv
// Per-master split mask: a SPLIT sets the bit, a slave release clears it, set wins.
module sb_arb_split_tracker (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] set_i,
    input  logic [1:0] release_i,
    output logic [1:0] mask_o
);

    logic [1:0] mask_q, mask_d;

    always_comb begin
        mask_d = set_i | (mask_q & ~release_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= 2'b00;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_o = mask_q;

endmodule

// File: rtl/sb_arbiter.sv
// Two-master SB bus arbiter with lock, hold limit and SPLIT masking.
// Define SB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority M1 over M2.
module sb_arbiter
    import sb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       sb_clk,
    input  logic       sb_reset,
    input  logic       sb_busreq_m1,
    input  logic       sb_busreq_m2,
    input  logic       sb_lock_m1,
    input  logic       sb_lock_m2,
    input  logic [1:0] sb_trans,
    input  logic       sb_ready,
    input  logic [1:0] sb_resp,
    input  logic [1:0] sb_split,
    output logic       sb_grant_m1,
    output logic       sb_grant_m2,
    output logic       sb_master,
    output logic       sb_mastlock
);

    arb_state_e        state_q, state_d, park_pick;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              mastlock_q, mastlock_d;
    logic [1:0]        split_mask, split_set;
    logic              elig_m1, elig_m2, owner_m2, boundary, beat, split_hit, hold_expired;
    logic [1:0]        state_bits;
    logic              fixed_prio;

    assign elig_m1      = sb_busreq_m1 & ~split_mask[0];
    assign elig_m2      = sb_busreq_m2 & ~split_mask[1];
    assign owner_m2     = (state_q == ArbM2);
    assign boundary     = sb_ready & ((sb_trans == TransIdle) | (sb_trans == TransNonseq));
    assign beat         = sb_ready & ((sb_trans == TransNonseq) | (sb_trans == TransSeq));
    assign split_hit    = sb_ready & (sb_resp == RespSplit);
    assign hold_expired = (hold_cnt_q >= HOLD_W'(MAX_HOLD));
    assign split_set    = split_hit ? (owner_m2 ? 2'b10 : 2'b01) : 2'b00;

`ifdef SB_ARB_ROUND_ROBIN_EN
    logic last_m2_q, last_m2_d;

    assign fixed_prio = 1'b0;
    assign park_pick  = last_m2_q ? ArbM1 : ArbM2;

    always_comb begin
        last_m2_d = last_m2_q;
        if (state_d == ArbM2) begin
            last_m2_d = 1'b1;
        end else if (state_d == ArbM1) begin
            last_m2_d = 1'b0;
        end
    end

    always_ff @(posedge sb_clk) begin
        if (sb_reset) begin
            last_m2_q <= 1'b0;
        end else begin
            last_m2_q <= last_m2_d;
        end
    end
`else
    assign fixed_prio = 1'b1;
    assign park_pick  = ArbM1;
`endif

    sb_arb_split_tracker u_split_tracker (
        .clk_i     (sb_clk),
        .rst_i     (sb_reset),
        .set_i     (split_set),
        .release_i (sb_split),
        .mask_o    (split_mask)
    );

    always_ff @(posedge sb_clk) begin
        if (sb_reset) begin
            state_q    <= ArbM1;
            hold_cnt_q <= '0;
            mastlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            mastlock_q <= mastlock_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mastlock_d = mastlock_q;
        if (split_hit) begin
            mastlock_d = 1'b0;
            if (owner_m2) begin
                state_d = elig_m1 ? ArbM1 : ArbPark;
            end else begin
                state_d = elig_m2 ? ArbM2 : ArbPark;
            end
        end else if (boundary) begin
            if (!mastlock_q) begin
                unique case (state_q)
                    ArbM1: begin
                        if ((!elig_m1 || hold_expired) && elig_m2) state_d = ArbM2;
                    end
                    ArbM2: begin
                        // Fixed priority lets M1 reclaim at M2's first boundary.
                        if (elig_m1 && (fixed_prio || !elig_m2 || hold_expired)) state_d = ArbM1;
                    end
                    ArbPark: begin
                        if (elig_m1 && elig_m2) state_d = park_pick;
                        else if (elig_m1)       state_d = ArbM1;
                        else if (elig_m2)       state_d = ArbM2;
                    end
                    default: state_d = ArbM1;
                endcase
            end
            unique case (state_d)
                ArbM1:   mastlock_d = sb_lock_m1;
                ArbM2:   mastlock_d = sb_lock_m2;
                default: mastlock_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if ((state_d == ArbM2) != owner_m2) begin
            hold_cnt_d = '0;
        end else if (beat && (hold_cnt_q != '1)) begin
            hold_cnt_d = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_bits  = state_q;
        sb_grant_m2 = state_bits[0];
        sb_grant_m1 = ~state_bits[0];
        sb_master   = state_bits[0] ? MasterM2 : MasterM1;
        sb_mastlock = mastlock_q;
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Bench for sb_arbiter: directed vector table, fairness count, random run vs. rule model.
module tb_sb_arbiter;

    localparam int unsigned MaxHold = 4;
    localparam int unsigned HoldW   = 3;
    localparam int          HoldSat = (1 << HoldW) - 1;
`ifdef SB_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic       sb_clk = 1'b0;
    logic       sb_reset = 1'b1;
    logic       sb_busreq_m1 = 1'b0, sb_busreq_m2 = 1'b0;
    logic       sb_lock_m1 = 1'b0, sb_lock_m2 = 1'b0;
    logic [1:0] sb_trans = 2'd0;
    logic       sb_ready = 1'b1;
    logic [1:0] sb_resp = 2'd1;
    logic [1:0] sb_split = 2'd0;
    logic       sb_grant_m1, sb_grant_m2, sb_master, sb_mastlock;
    logic [3:0] dut_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner 1 = M1, 2 = M2, 0 = parked (grant shown on M1).
    int m_owner, m_hold, m_last;
    bit m_lock;
    bit m_mask [3];

    typedef struct {
        logic       rst, req1, req2, lock1, lock2;
        logic [1:0] trans;
        logic       ready;
        logic [1:0] resp, split;
        logic [3:0] exp;  // {grant_m1, grant_m2, master, mastlock}
    } vec_t;

    vec_t vecs[$];

    sb_arbiter #(
        .MAX_HOLD (MaxHold),
        .HOLD_W   (HoldW)
    ) dut (
        .sb_clk       (sb_clk),
        .sb_reset     (sb_reset),
        .sb_busreq_m1 (sb_busreq_m1),
        .sb_busreq_m2 (sb_busreq_m2),
        .sb_lock_m1   (sb_lock_m1),
        .sb_lock_m2   (sb_lock_m2),
        .sb_trans     (sb_trans),
        .sb_ready     (sb_ready),
        .sb_resp      (sb_resp),
        .sb_split     (sb_split),
        .sb_grant_m1  (sb_grant_m1),
        .sb_grant_m2  (sb_grant_m2),
        .sb_master    (sb_master),
        .sb_mastlock  (sb_mastlock)
    );

    assign dut_out = {sb_grant_m1, sb_grant_m2, sb_master, sb_mastlock};

    always #5 sb_clk = ~sb_clk;

    function automatic vec_t mk(input logic rst, input logic req1, input logic req2,
                                input logic lock1, input logic lock2, input logic [1:0] trans,
                                input logic ready, input logic [1:0] resp,
                                input logic [1:0] split, input logic [3:0] exp);
        vec_t v;
        v.rst = rst; v.req1 = req1; v.req2 = req2; v.lock1 = lock1; v.lock2 = lock2;
        v.trans = trans; v.ready = ready; v.resp = resp; v.split = split; v.exp = exp;
        return v;
    endfunction

    function automatic logic [3:0] model_out();
        logic g1;
        g1 = (m_owner != 2);
        return {g1, ~g1, g1, m_lock};
    endfunction

    task automatic model_step(input vec_t v);
        int  nxt, other, gm, gm_new;
        bit  e [3];
        bit  set_b [3];
        if (v.rst) begin
            m_owner = 1; m_hold = 0; m_last = 1; m_lock = 1'b0;
            m_mask[1] = 1'b0; m_mask[2] = 1'b0;
            return;
        end
        e[0] = 1'b0;
        e[1] = v.req1 && !m_mask[1];
        e[2] = v.req2 && !m_mask[2];
        set_b[0] = 1'b0; set_b[1] = 1'b0; set_b[2] = 1'b0;
        gm  = (m_owner == 2) ? 2 : 1;
        nxt = m_owner;
        if (v.ready && v.resp == 2'd3) begin
            set_b[gm] = 1'b1;
            other = 3 - gm;
            nxt = e[other] ? other : 0;
            m_lock = 1'b0;
        end else if (v.ready && (v.trans == 2'd0 || v.trans == 2'd2)) begin
            if (!m_lock) begin
                if (m_owner == 0) begin
                    if (e[1] && e[2]) nxt = RoundRobin ? 3 - m_last : 1;
                    else if (e[1])    nxt = 1;
                    else if (e[2])    nxt = 2;
                end else begin
                    other = 3 - m_owner;
                    if (!RoundRobin && m_owner == 2 && e[1]) nxt = 1;
                    else if ((!e[m_owner] || m_hold >= int'(MaxHold)) && e[other]) nxt = other;
                end
            end
            m_lock = (nxt == 1) ? v.lock1 : (nxt == 2) ? v.lock2 : 1'b0;
        end
        for (int n = 1; n <= 2; n++) begin
            if (set_b[n])           m_mask[n] = 1'b1;
            else if (v.split[n-1])  m_mask[n] = 1'b0;
        end
        gm_new = (nxt == 2) ? 2 : 1;
        if (gm_new != gm)                  m_hold = 0;
        else if (v.ready && v.trans[1])    m_hold = (m_hold < HoldSat) ? m_hold + 1 : m_hold;
        if (nxt != 0) m_last = nxt;
        m_owner = nxt;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got g1/g2/master/lock=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_reset = v.rst; sb_busreq_m1 = v.req1; sb_busreq_m2 = v.req2;
        sb_lock_m1 = v.lock1; sb_lock_m2 = v.lock2; sb_trans = v.trans;
        sb_ready = v.ready; sb_resp = v.resp; sb_split = v.split;
        @(posedge sb_clk);
        #1;
        model_step(v);
    endtask

    initial begin
        vec_t v;
        int   m2_cycles;
        int   exp_m2;

        // rst r1 r2 l1 l2 trans ready resp split exp
        vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b1010)); // reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b1010)); // idle park
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b1010));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b1010)); // M1 burst, hold 1
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd3, 1, 2'd1, 2'b00, 4'b1010)); // M2 req mid-burst
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd3, 1, 2'd1, 2'b00, 4'b1010));
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd3, 1, 2'd1, 2'b00, 4'b1010)); // hold 4
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b0100)); // forced hand-off
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b1010)); // priority back to M1
        vecs.push_back(mk(0, 1, 0, 1, 0, 2'd2, 1, 2'd1, 2'b00, 4'b1011)); // lock taken
        vecs.push_back(mk(0, 1, 1, 1, 0, 2'd3, 1, 2'd1, 2'b00, 4'b1011));
        vecs.push_back(mk(0, 1, 1, 1, 0, 2'd2, 1, 2'd1, 2'b00, 4'b1011)); // locked boundary
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b1010)); // lock drops, no rearb
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b0100)); // M1 done -> M2
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b0100));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2'd3, 1, 2'd3, 2'b00, 4'b1010)); // SPLIT M2 -> M1
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b1010)); // M2 masked
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd3, 1, 2'd3, 2'b00, 4'b1010)); // SPLIT M1 -> park
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b1010)); // both masked
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd0, 1, 2'd1, 2'b10, 4'b1010)); // release M2
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b0100)); // M2 granted
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 2'd3, 2'b10, 4'b1010)); // SPLIT beats release
        vecs.push_back(mk(0, 1, 1, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b1010)); // M2 still masked
        vecs.push_back(mk(0, 1, 0, 0, 0, 2'd0, 1, 2'd1, 2'b01, 4'b1010)); // release M1
        vecs.push_back(mk(0, 1, 0, 1, 0, 2'd0, 1, 2'd1, 2'b00, 4'b1011)); // M1 out of park
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'd3, 1, 2'd1, 2'b00, 4'b1010)); // reset mid-transfer

        if (!RoundRobin) begin
            foreach (vecs[i]) begin
                apply(vecs[i]);
                check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
            end
        end else begin
            foreach (vecs[i]) begin
                apply(vecs[i]);
                check($sformatf("vec%0d_model", i), dut_out, model_out());
            end
        end

        // Both masters streaming single-beat NONSEQs: count M2 tenure cycles.
        apply(mk(1, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b0000));
        m2_cycles = 0;
        for (int c = 0; c < 30; c++) begin
            apply(mk(0, 1, 1, 0, 0, 2'd2, 1, 2'd1, 2'b00, 4'b0000));
            if (sb_grant_m2 === 1'b1) m2_cycles++;
        end
        exp_m2 = RoundRobin ? 15 : 5;
        n_tests++;
        if (m2_cycles != exp_m2) begin
            n_fail++;
            $display("FAIL fairness: M2 granted %0d of 30 cycles, expected %0d", m2_cycles, exp_m2);
        end

        // Random run against the model.
        apply(mk(1, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'b00, 4'b0000));
        for (int c = 0; c < 3000; c++) begin
            v.rst   = ($urandom_range(199) == 0);
            v.req1  = ($urandom_range(9) < 7);
            v.req2  = ($urandom_range(9) < 7);
            v.lock1 = ($urandom_range(3) == 0);
            v.lock2 = ($urandom_range(3) == 0);
            v.trans = 2'($urandom_range(3));
            v.ready = ($urandom_range(3) != 0);
            v.resp  = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
            v.split = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
            v.exp   = 4'b0000;
            apply(v);
            check($sformatf("rand%0d", c), dut_out, model_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_arbiter.md
# sb_arbiter

Two-master bus arbiter for the SB bus. It grants bus ownership to master 1 or master 2 and drives the master ID seen by every slave (`sb_master_sN`). It honours locked sequences and tracks SPLIT responses, masking a split master until a slave releases it through its split vector. It sits between the two SB masters and the address/write-data mux that feeds the slaves.

## Interface
- `MAX_HOLD`, default 16: data beats a master may hold the bus before forced re-arbitration (unlocked only).
- `HOLD_W`, default 5: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- `sb_clk` in 1: bus clock.
- `sb_reset` in 1: reset, synchronous, active-high.
- `sb_busreq_m1`, `sb_busreq_m2` in 1 each: bus requests.
- `sb_lock_m1`, `sb_lock_m2` in 1 each: locked-sequence requests.
- `sb_trans` in 2: transfer type of the current owner, from the mux. IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `sb_ready` in 1: muxed slave ready.
- `sb_resp` in 2: muxed response. OKAY=1, ERROR=2, SPLIT=3.
- `sb_split` in 2: OR of all slave split vectors. Bit0 releases M1, bit1 releases M2.
- `sb_grant_m1`, `sb_grant_m2` out 1 each: one-hot grant.
- `sb_master` out 1: current owner. 1=M1, 0=M2.
- `sb_mastlock` out 1: owner holds a locked sequence.

## Operation
- Reset values: `sb_grant_m1`=1, `sb_grant_m2`=0, `sb_master`=1, `sb_mastlock`=0. Internally, split_mask=00, hold_cnt=0, state=ARB_M1.
- States:
  - ARB_M1: M1 owns the bus.
  - ARB_M2: M2 owns the bus.
  - ARB_PARK: both masters are split-masked. Grant parks on M1 and M1 must drive IDLE.
- Eligible master: busreq=1 and its split_mask bit=0.
- Boundary: `sb_ready`=1 and `sb_trans` ∈ {IDLE, NONSEQ}, sampled at the current edge. Arbitration happens only at a boundary.
- At a boundary, unless `sb_mastlock`=1:
  - If the owner is not requesting, or hold_cnt ≥ MAX_HOLD, pick the other eligible master.
  - Otherwise keep the owner.
- No eligible master: keep the current grant (park). If both are masked, go to ARB_PARK.
- Locked: `sb_mastlock` follows the owner's lock bit at each boundary. While it is 1, no re-arbitration happens, hold_cnt is ignored, and SPLIT is still honoured.
- hold_cnt:
  - Increments on each `sb_ready`=1 with `sb_trans` ∈ {NONSEQ, SEQ}.
  - Clears on a grant change.
  - Saturates at 2^HOLD_W−1.
- SPLIT: `sb_resp`=SPLIT with `sb_ready`=1 has these effects, all on that edge:
  - Sets the owner's split_mask bit.
  - Clears `sb_mastlock`.
  - Forces re-arbitration to the other master if eligible, else to ARB_PARK.
- Release: `sb_split` bit n=1 clears split_mask bit n on that edge.
  - A release and a SPLIT for the same master on the same edge: SPLIT wins.
  - A released master becomes eligible on the following cycle.
- ERROR response: no arbitration effect.
- Reset asserted mid-transfer: all state returns to reset values on that edge.

## Timing
- Request to grant: one cycle after the qualifying boundary edge at the earliest.
- Grant outputs are registered and glitch-free. `sb_master` changes on the same edge as the grants.
- Handover: the new owner may drive NONSEQ on the cycle after its grant rises. The old owner's final data beat completes in that cycle (address/data pipeline).
- SPLIT-to-regrant: one edge.
- Split release to possible grant: two edges (mask clear, then arbitration).

## Configuration
- `SB_ARB_ROUND_ROBIN_EN` defined: when both masters are eligible at a re-arbitration point, the master that did not own the bus last wins. Forced hand-off via MAX_HOLD alternates.
- `SB_ARB_ROUND_ROBIN_EN` undefined: fixed priority, M1 over M2. MAX_HOLD still forces a hand-off to an eligible M2 for one tenure, then priority resumes.

## Structure
- Shared package `sb_pkg`: trans encodings (IDLE/BUSY/NONSEQ/SEQ), resp encodings (OKAY/ERROR/SPLIT), master ID constants (M1=1, M2=0), and the arbiter state enum.
- One natural sub-module, `sb_arb_split_tracker`: the 2-bit split_mask register with set/release priority. Everything else stays in `sb_arbiter`.

## Test plan
- Reset, then no requests → `sb_grant_m1`=1, `sb_master`=1, `sb_mastlock`=0, held indefinitely.
- M1 in an 8-beat burst, M2 requests at beat 3 → M2 is granted one cycle after M1's next boundary. With MAX_HOLD=4, the hand-off occurs at the first boundary with hold_cnt ≥ 4.
- M1 locked 4-beat write with M2 requesting → grant stays on M1 until the boundary after the lock drops. `sb_mastlock`=1 throughout.
- Slave returns SPLIT to M1 while M2 requests → the next edge gives `sb_grant_m2`=1 and M1 is masked. `sb_split`=01 → M1 is eligible again two edges later.
- Both masters split → ARB_PARK with grant on M1. Release `sb_split`=10 → M2 is granted at the next boundary.
- Both masters request continuously:
  - Round-robin build: grants alternate.
  - Fixed-priority build: M1 holds except for one forced M2 tenure per MAX_HOLD expiry.
